// File: rtl/router_pkt_framer.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_framer
// Description : Store-and-forward packet source for the 1x3 router. Accepts
//               a command (destination address + payload length) and the
//               payload bytes from a client, buffers the whole payload, then
//               emits header, contiguous payload and trailing parity byte to
//               the router while honouring its busy back-pressure.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   GAP_CYCLES  minimum idle cycles between a parity byte and the next header
// Ports
//   clock, reset          single rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (cmd_addr 0..2, cmd_len 1..63)
//   cmd_err               one-cycle pulse for a rejected command
//   pay_valid/pay_ready   payload byte handshake, pay_data is the byte
//   pkt_valid, pkt_data   registered drive of the router input
//   busy                  router back-pressure, holds the current byte
//   done                  one-cycle pulse when the parity byte is accepted
//   pkt_count             completed packets, wraps at 16 bits
// Optional feature
//   ROUTER_FRAMER_ERR_INJECT_EN : adds input err_inject, sampled with the
//   accepted command; when set the transmitted parity has bit 0 inverted.
// ============================================================================
module router_pkt_framer #(
    parameter int GAP_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_addr,
    input  logic [5:0]  cmd_len,
    output logic        cmd_err,
`ifdef ROUTER_FRAMER_ERR_INJECT_EN
    input  logic        err_inject,
`endif
    input  logic        pay_valid,
    output logic        pay_ready,
    input  logic [7:0]  pay_data,
    output logic        pkt_valid,
    output logic [7:0]  pkt_data,
    input  logic        busy,
    output logic        done,
    output logic [15:0] pkt_count
);

    localparam int C_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [C_GAP_W-1:0] C_GAP_LAST =
        C_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_HEADER  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_PARITY  = 3'd4,
        S_GAP     = 3'd5
    } t_state;

    t_state               r_state;
    logic [5:0]           r_idx;
    logic [5:0]           r_len;
    logic [1:0]           r_addr;
    logic [7:0]           r_parity;
    logic [C_GAP_W-1:0]   r_gap_cnt;
    logic                 r_pkt_valid;
    logic [7:0]           r_pkt_data;
    logic                 r_done;
    logic                 r_cmd_err;
    logic [15:0]          r_pkt_count;
    logic [7:0]           r_buf [64];

    logic                 w_cmd_bad;
    logic                 w_pay_fire;
    logic                 w_last;
    logic [7:0]           w_par_out;

    assign w_cmd_bad  = (cmd_addr == 2'd3) || (cmd_len == 6'd0);
    assign w_pay_fire = !reset && (r_state == S_LOAD) && pay_valid;
    // r_idx points at the byte being loaded or currently driven
    assign w_last     = (r_idx == (r_len - 6'd1));

`ifdef ROUTER_FRAMER_ERR_INJECT_EN
    logic r_inject;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_inject <= 1'b0;
        end else if ((r_state == S_IDLE) && cmd_valid && !w_cmd_bad) begin
            r_inject <= err_inject;
        end
    end

    assign w_par_out = r_parity ^ {7'd0, r_inject};
`else
    assign w_par_out = r_parity;
`endif

    // Handshake readies are pure state decodes, blocked during reset
    assign cmd_ready = !reset && (r_state == S_IDLE);
    assign pay_ready = !reset && (r_state == S_LOAD);

    assign pkt_valid = r_pkt_valid;
    assign pkt_data  = r_pkt_data;
    assign done      = r_done;
    assign cmd_err   = r_cmd_err;
    assign pkt_count = r_pkt_count;

    // Payload storage needs no reset: it is always written before being read
    always_ff @(posedge clock) begin
        if (w_pay_fire) begin
            r_buf[r_idx] <= pay_data;
        end
    end

    // Outputs are registered together with the state so that pkt_valid and
    // pkt_data always describe the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= 6'd0;
            r_len       <= 6'd0;
            r_addr      <= 2'd0;
            r_parity    <= 8'd0;
            r_gap_cnt   <= '0;
            r_pkt_valid <= 1'b0;
            r_pkt_data  <= 8'd0;
            r_done      <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_pkt_count <= 16'd0;
        end else begin
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (w_cmd_bad) begin
                            r_cmd_err <= 1'b1;
                        end else begin
                            r_addr   <= cmd_addr;
                            r_len    <= cmd_len;
                            r_parity <= {cmd_len, cmd_addr};
                            r_idx    <= 6'd0;
                            r_state  <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (pay_valid) begin
                        r_parity <= r_parity ^ pay_data;
                        if (w_last) begin
                            r_idx       <= 6'd0;
                            r_state     <= S_HEADER;
                            r_pkt_valid <= 1'b1;
                            r_pkt_data  <= {r_len, r_addr};
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                S_HEADER: begin
                    if (!busy) begin
                        r_state    <= S_PAYLOAD;
                        r_pkt_data <= r_buf[r_idx];
                    end
                end
                S_PAYLOAD: begin
                    if (!busy) begin
                        if (w_last) begin
                            r_state     <= S_PARITY;
                            r_pkt_valid <= 1'b0;
                            r_pkt_data  <= w_par_out;
                        end else begin
                            r_idx      <= r_idx + 6'd1;
                            r_pkt_data <= r_buf[r_idx + 6'd1];
                        end
                    end
                end
                S_PARITY: begin
                    if (!busy) begin
                        r_done      <= 1'b1;
                        r_pkt_count <= r_pkt_count + 16'd1;
                        r_pkt_data  <= 8'd0;
                        r_gap_cnt   <= '0;
                        r_state     <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == C_GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + C_GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_pkt_framer
// Description : Directed self-checking bench for router_pkt_framer. Inputs
//               are driven 1 ns after each rising edge and outputs sampled
//               at the same point; expected bytes are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_framer;

    localparam int GAP = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_addr;
    logic [5:0]  cmd_len;
    logic        cmd_err;
    logic        pay_valid;
    logic        pay_ready;
    logic [7:0]  pay_data;
    logic        pkt_valid;
    logic [7:0]  pkt_data;
    logic        busy;
    logic        done;
    logic [15:0] pkt_count;
`ifdef ROUTER_FRAMER_ERR_INJECT_EN
    logic        err_inject;
`endif

    int          n_tests   = 0;
    int          n_fail    = 0;
    int          exp_count = 0;
    logic [7:0]  pay [64];

    always #5 clock = ~clock;

    router_pkt_framer #(.GAP_CYCLES(GAP)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_err   (cmd_err),
`ifdef ROUTER_FRAMER_ERR_INJECT_EN
        .err_inject(err_inject),
`endif
        .pay_valid (pay_valid),
        .pay_ready (pay_ready),
        .pay_data  (pay_data),
        .pkt_valid (pkt_valid),
        .pkt_data  (pkt_data),
        .busy      (busy),
        .done      (done),
        .pkt_count (pkt_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_pkt_data",  pkt_data,  0);
        chk("rst_done",      done,      0);
        chk("rst_cmd_err",   cmd_err,   0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_pay_ready", pay_ready, 0);
        reset = 1'b0;
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);
        chk("rel_pay_ready", pay_ready, 0);
        chk("rel_pkt_valid", pkt_valid, 0);
        exp_count = 0;
    endtask

    task automatic issue_cmd(input logic [1:0] a, input logic [5:0] l);
        int w;
        w = 0;
        while (!cmd_ready && w < 100) begin
            tick();
            w++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        tick();
        cmd_valid = 1'b0;
        chk("cmd_err_legal", cmd_err, 0);
    endtask

    task automatic load(input int l, input int gap_at);
        for (int i = 0; i < l; i++) begin
            if (i == gap_at) begin
                pay_valid = 1'b0;
                tick();
                chk("gap_invisible", pkt_valid, 0);
            end
            pay_valid = 1'b1;
            pay_data  = pay[i];
            chk("pay_ready", pay_ready, 1);
            tick();
        end
        pay_valid = 1'b0;
    endtask

    // Walks header, payload and parity one observed cycle at a time,
    // optionally stalling stall_n cycles on byte stall_k, or stopping while
    // byte abort_k is driven (k=0 is the header).
    task automatic stream(input int l, input logic [7:0] hdr, input logic [7:0] par,
                          input int stall_k, input int stall_n, input int abort_k);
        logic [7:0] e;
        int         holds;
        int         w;
        for (int k = 0; k < l + 2; k++) begin
            e     = (k == 0) ? hdr : ((k <= l) ? pay[k-1] : par);
            holds = (k == stall_k) ? stall_n + 1 : 1;
            if (k == abort_k) begin
                chk("abort_byte", pkt_data, e);
                return;
            end
            for (int h = 0; h < holds; h++) begin
                busy = (h < holds - 1);
                chk("pkt_data",  pkt_data,  e);
                chk("pkt_valid", pkt_valid, (k <= l) ? 1 : 0);
                tick();
            end
        end
        busy = 1'b0;
        exp_count++;
        chk("done_pulse", done,      1);
        chk("pkt_count",  pkt_count, exp_count);
        chk("post_valid", pkt_valid, 0);
        w = 0;
        while (!cmd_ready && w < 50) begin
            tick();
            w++;
            if (w == 1) chk("done_width", done, 0);
        end
        chk("gap_cycles", w, GAP);
    endtask

    task automatic illegal(input logic [1:0] a, input logic [5:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        chk("ill_ready_pre", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("ill_cmd_err",   cmd_err,   1);
        chk("ill_pkt_valid", pkt_valid, 0);
        chk("ill_ready",     cmd_ready, 1);
        chk("ill_pay_ready", pay_ready, 0);
        tick();
        chk("ill_err_pulse", cmd_err,   0);
        chk("ill_ready2",    cmd_ready, 1);
        chk("ill_valid2",    pkt_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 2'd0;
        cmd_len   = 6'd0;
        pay_valid = 1'b0;
        pay_data  = 8'd0;
        busy      = 1'b0;
`ifdef ROUTER_FRAMER_ERR_INJECT_EN
        err_inject = 1'b0;
`endif
        tick();
        do_reset();

        // Basic packet, with one client gap while loading
        for (int i = 0; i < 14; i++) pay[i] = 8'(i + 1);
        issue_cmd(2'd1, 6'd14);
        load(14, 4);
        stream(14, 8'h39, 8'h36, -1, 0, -1);

        // Same packet, router busy for 3 cycles on payload byte 0x05
        issue_cmd(2'd1, 6'd14);
        load(14, -1);
        stream(14, 8'h39, 8'h36, 5, 3, -1);

        // Rejected commands
        illegal(2'd3, 6'd4);
        illegal(2'd0, 6'd0);
        chk("ill_count", pkt_count, 2);

        // Reset while the 7th payload byte is on the wire
        issue_cmd(2'd1, 6'd14);
        load(14, -1);
        stream(14, 8'h39, 8'h36, -1, 0, 7);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", pkt_valid, 0);
        chk("mid_rst_count", pkt_count, 0);
        chk("mid_rst_done",  done,      0);
        chk("mid_rst_ready", cmd_ready, 0);
        reset = 1'b0;
        #1;
        chk("mid_rel_ready", cmd_ready, 1);
        exp_count = 0;
        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'h7F;
        issue_cmd(2'd2, 6'd3);
        load(3, -1);
        stream(3, 8'h0E, 8'h02, -1, 0, -1);

        // Back-to-back packets from a fresh reset
        do_reset();
        pay[0] = 8'hAA;
        issue_cmd(2'd2, 6'd1);
        load(1, -1);
        stream(1, 8'h06, 8'hAC, -1, 0, -1);
        pay[0] = 8'h55; pay[1] = 8'h0F;
        issue_cmd(2'd0, 6'd2);
        load(2, -1);
        stream(2, 8'h08, 8'h52, 1, 2, -1);
        chk("b2b_count", pkt_count, 2);

`ifdef ROUTER_FRAMER_ERR_INJECT_EN
        for (int i = 0; i < 14; i++) pay[i] = 8'(i + 1);
        err_inject = 1'b1;
        issue_cmd(2'd1, 6'd14);
        err_inject = 1'b0;
        load(14, -1);
        stream(14, 8'h39, 8'h37, -1, 0, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
